// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Shared definitions for the 16-bit pipeline memory stage:
//               opcode class constants, mem-op class and request FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int RD_W_DEF   = 3;

  // Patterns of opcode[5:2]
  localparam logic [3:0] OPC_LW = 4'b0100;
  localparam logic [3:0] OPC_SW = 4'b0101;
  localparam logic [3:0] OPC_LM = 4'b0110;
  localparam logic [3:0] OPC_SM = 4'b0111;

  typedef enum logic [1:0] {
    CLS_PASS  = 2'd0,
    CLS_LOAD  = 2'd1,
    CLS_STORE = 2'd2
  } mem_class_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  function automatic mem_class_e decode_class(input logic [3:0] op);
    case (op)
      OPC_LW, OPC_LM: decode_class = CLS_LOAD;
      OPC_SW, OPC_SM: decode_class = CLS_STORE;
      default:        decode_class = CLS_PASS;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_req_fsm.sv
`default_nettype none
// ============================================================================
// Module      : dmem_req_fsm
// Description : Data-memory request sequencer. Tracks the req/gnt/rvalid
//               handshake for the instruction held in the M register and
//               produces completion, accept and back-pressure to execute.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_req_fsm
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       ex_valid,
  input  mem_class_e ex_class,
  input  logic       m_valid,
  input  mem_class_e m_class,
  input  logic       dmem_gnt,
  input  logic       dmem_rvalid,
  output logic       dmem_req,
  output logic       complete,
  output logic       ex_ready,
  output logic       accept
);

  mem_state_e r_state;
  mem_state_e w_state_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    complete    = 1'b0;
    dmem_req    = 1'b0;
    ex_ready    = 1'b0;
    accept      = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // In IDLE a valid M entry can only be a pass-through op
        complete = m_valid;
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        if (dmem_gnt) begin
          if (m_class == CLS_LOAD) begin
            w_state_nxt = ST_RESP;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (dmem_rvalid) begin
          complete = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    ex_ready = !m_valid || complete;
    accept   = ex_valid && ex_ready;

    // When M drains (or is empty) the next state follows the incoming op
    if (ex_ready) begin
      w_state_nxt = (accept && (ex_class != CLS_PASS)) ? ST_REQ : ST_IDLE;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_stage
// Description : Pipeline memory stage. Holds the EX/MEM register, performs
//               loads/stores over a req/gnt/rvalid data-memory port and
//               delivers a registered single-cycle result to write-back.
//               Option macro: MEM_LOAD_ZFLAG_EN (LW sets Z from load data).
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_W   = RD_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        opcode_ex,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [DATA_W-1:0] Data_2_ex_updated,
  input  logic              reg_write_ex_updated,
  input  logic [RD_W-1:0]   rd_ex,
  input  logic              cout_n,
  input  logic              zout_n,
  output logic              mem_stall,
  output logic [DATA_W-1:0] Data_from_mem,
  output logic              mem_fwd_valid,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_gnt,
  input  logic              dmem_rvalid,
  input  logic [DATA_W-1:0] dmem_rdata,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [RD_W-1:0]   wb_rd,
  output logic              wb_reg_write,
  output logic              wb_cflag,
  output logic              wb_zflag
);

  mem_class_e        w_ex_class;
  logic              w_accept;
  logic              w_complete;
  logic              w_ex_ready;
  logic              w_dmem_req;
  logic [DATA_W-1:0] w_wb_data;
  logic              w_wb_zflag;
  logic              w_unused_opc;

  logic              r_m_valid;
  mem_class_e        r_m_class;
  logic [DATA_W-1:0] r_m_addr;
  logic [DATA_W-1:0] r_m_wdata;
  logic [RD_W-1:0]   r_m_rd;
  logic              r_m_reg_write;
  logic              r_m_cout;
  logic              r_m_zout;

  logic              r_wb_valid;
  logic [DATA_W-1:0] r_wb_data;
  logic [RD_W-1:0]   r_wb_rd;
  logic              r_wb_reg_write;
  logic              r_wb_cflag;
  logic              r_wb_zflag;

  assign w_ex_class   = decode_class(opcode_ex[5:2]);
  assign w_unused_opc = ^opcode_ex[1:0];

  dmem_req_fsm u_fsm (
    .clk         (clk),
    .rst         (rst),
    .ex_valid    (ex_valid),
    .ex_class    (w_ex_class),
    .m_valid     (r_m_valid),
    .m_class     (r_m_class),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_req    (w_dmem_req),
    .complete    (w_complete),
    .ex_ready    (w_ex_ready),
    .accept      (w_accept)
  );

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_valid     <= 1'b0;
      r_m_class     <= CLS_PASS;
      r_m_addr      <= '0;
      r_m_wdata     <= '0;
      r_m_rd        <= '0;
      r_m_reg_write <= 1'b0;
      r_m_cout      <= 1'b0;
      r_m_zout      <= 1'b0;
    end else if (w_accept) begin
      r_m_valid     <= 1'b1;
      r_m_class     <= w_ex_class;
      r_m_addr      <= alu_out;
      r_m_wdata     <= Data_2_ex_updated;
      r_m_rd        <= rd_ex;
      r_m_reg_write <= reg_write_ex_updated;
      r_m_cout      <= cout_n;
      r_m_zout      <= zout_n;
    end else if (w_complete) begin
      r_m_valid     <= 1'b0;
    end
  end

`ifdef MEM_LOAD_ZFLAG_EN
  logic r_m_is_lw;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_m_is_lw <= 1'b0;
    end else if (w_accept) begin
      r_m_is_lw <= (opcode_ex[5:2] == OPC_LW);
    end
  end

  // Loads only complete on rvalid, so rdata is valid whenever this is used
  assign w_wb_zflag = r_m_is_lw ? (dmem_rdata == '0) : r_m_zout;
`else
  assign w_wb_zflag = r_m_zout;
`endif

  assign w_wb_data = (r_m_class == CLS_LOAD) ? dmem_rdata : r_m_addr;

  // Write-back register: one pulse per completed instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_valid     <= 1'b0;
      r_wb_data      <= '0;
      r_wb_rd        <= '0;
      r_wb_reg_write <= 1'b0;
      r_wb_cflag     <= 1'b0;
      r_wb_zflag     <= 1'b0;
    end else begin
      r_wb_valid <= w_complete;
      if (w_complete) begin
        r_wb_data      <= w_wb_data;
        r_wb_rd        <= r_m_rd;
        r_wb_reg_write <= r_m_reg_write && (r_m_class != CLS_STORE);
        r_wb_cflag     <= r_m_cout;
        r_wb_zflag     <= w_wb_zflag;
      end
    end
  end

  assign ex_ready      = w_ex_ready;
  assign mem_stall     = ~w_ex_ready;
  assign Data_from_mem = r_m_addr;
  assign mem_fwd_valid = r_m_valid && (r_m_class != CLS_LOAD);

  assign dmem_req      = w_dmem_req;
  assign dmem_we       = (r_m_class == CLS_STORE);
  assign dmem_addr     = r_m_addr;
  assign dmem_wdata    = r_m_wdata;

  assign wb_valid      = r_wb_valid;
  assign wb_data       = r_wb_data;
  assign wb_rd         = r_wb_rd;
  assign wb_reg_write  = r_wb_reg_write;
  assign wb_cflag      = r_wb_cflag;
  assign wb_zflag      = r_wb_zflag;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_access_stage
// Description : Self-checking bench for mem_access_stage with a randomized
//               data-memory responder and an ISA-level result model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid, ex_ready, mem_stall, mem_fwd_valid;
  logic [5:0]  opcode_ex;
  logic [15:0] alu_out, Data_2_ex_updated, Data_from_mem;
  logic        reg_write_ex_updated, cout_n, zout_n;
  logic [2:0]  rd_ex, wb_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [15:0] dmem_addr, dmem_wdata, dmem_rdata, wb_data;
  logic        wb_valid, wb_reg_write, wb_cflag, wb_zflag;

  mem_access_stage #(.DATA_W(16), .RD_W(3)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .opcode_ex(opcode_ex), .alu_out(alu_out), .Data_2_ex_updated(Data_2_ex_updated),
    .reg_write_ex_updated(reg_write_ex_updated), .rd_ex(rd_ex),
    .cout_n(cout_n), .zout_n(zout_n), .mem_stall(mem_stall),
    .Data_from_mem(Data_from_mem), .mem_fwd_valid(mem_fwd_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid),
    .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .wb_cflag(wb_cflag),
    .wb_zflag(wb_zflag)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] data;
    logic [2:0]  rd;
    logic        rw;
    logic        c;
    logic        z;
    int          cyc;
  } wb_t;

  wb_t obs_q[$];
  wb_t exp_q[$];
  int  checks = 0;
  int  passes = 0;

  logic [15:0] ref_mem  [0:255];
  logic [15:0] resp_mem [0:255];

  int gnt_lat  = 0;
  int rv_lat   = 1;
  bit resp_en  = 1'b1;
  bit stray_en = 1'b0;

  // Write-back observer: records every pulse with its cycle number
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (wb_valid) begin
        e.data = wb_data; e.rd = wb_rd; e.rw = wb_reg_write;
        e.c = wb_cflag; e.z = wb_zflag; e.cyc = cyc;
        obs_q.push_back(e);
      end
    end
  end

  // Data-memory responder with programmable grant and read latency
  initial begin
    int          req_cnt = 0;
    int          rv_cnt = 0;
    bit          pend = 1'b0;
    bit          g_real = 1'b0;
    bit          g_we = 1'b0;
    logic [15:0] g_addr = '0;
    logic [15:0] g_wdata = '0;
    logic [15:0] p_addr = '0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        req_cnt = 0; pend = 1'b0; g_real = 1'b0;
        if (resp_en) begin dmem_gnt = 1'b0; dmem_rvalid = 1'b0; end
      end else if (resp_en) begin
        if (g_real) begin
          if (g_we) resp_mem[g_addr[7:0]] = g_wdata;
          else begin pend = 1'b1; rv_cnt = 0; p_addr = g_addr; end
          req_cnt = 0;
        end
        g_real = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 16'($urandom);
        if (pend) begin
          rv_cnt++;
          if (rv_cnt >= rv_lat) begin
            dmem_rvalid = 1'b1; dmem_rdata = resp_mem[p_addr[7:0]]; pend = 1'b0;
          end
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
          dmem_rvalid = 1'b1;
        end
        if (dmem_req) begin
          if (req_cnt >= gnt_lat) begin
            dmem_gnt = 1'b1; g_real = 1'b1;
            g_we = dmem_we; g_addr = dmem_addr; g_wdata = dmem_wdata;
          end
          req_cnt++;
        end else if (stray_en && $urandom_range(0, 3) == 0) begin
          dmem_gnt = 1'b1;
        end
      end
    end
  end

  // Architectural result of one instruction, in program order
  function automatic wb_t model(input logic [5:0] op, input logic [15:0] alu,
                                input logic [15:0] d2, input logic rw,
                                input logic [2:0] rd, input logic c, input logic z);
    wb_t e;
    logic [3:0] k;
    k = op[5:2];
    e.rd = rd; e.c = c; e.z = z; e.rw = rw; e.data = alu; e.cyc = 0;
    if (k == 4'b0100 || k == 4'b0110) begin
      e.data = ref_mem[alu[7:0]];
`ifdef MEM_LOAD_ZFLAG_EN
      if (k == 4'b0100) e.z = (e.data == 16'h0000);
`endif
    end else if (k == 4'b0101 || k == 4'b0111) begin
      ref_mem[alu[7:0]] = d2;
      e.rw = 1'b0;
    end
    return e;
  endfunction

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic set_mem(input logic [7:0] a, input logic [15:0] v);
    ref_mem[a] = v; resp_mem[a] = v;
  endtask

  // Presents one instruction and holds it until the stage accepts it
  task automatic issue(input logic [5:0] op, input logic [15:0] alu, input logic [15:0] d2,
                       input logic rw, input logic [2:0] rd, input logic c, input logic z,
                       output int acc);
    int n;
    n = 0;
    ex_valid = 1'b1; opcode_ex = op; alu_out = alu; Data_2_ex_updated = d2;
    reg_write_ex_updated = rw; rd_ex = rd; cout_n = c; zout_n = z;
    while (!ex_ready && n < 200) begin tick(); n++; end
    acc = cyc + 1;
    if (n >= 200) begin
      checks++;
      $display("FAIL issue_timeout ex_ready=%b required=1", ex_ready);
      acc = -1;
    end else begin
      exp_q.push_back(model(op, alu, d2, rw, rd, c, z));
    end
    tick();
    ex_valid = 1'b0; opcode_ex = 6'($urandom); alu_out = 16'($urandom);
    Data_2_ex_updated = 16'($urandom); rd_ex = 3'($urandom);
  endtask

  task automatic wait_wb(input int n);
    int k;
    k = 0;
    while (obs_q.size() < n && k < 300) begin tick(); k++; end
    repeat (3) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++; if (ex_ready !== 1'b1) $display("FAIL rst_ex_ready got=%b req=1", ex_ready); else passes++;
    checks++; if (mem_stall !== 1'b0) $display("FAIL rst_mem_stall got=%b req=0", mem_stall); else passes++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL rst_dmem_req got=%b req=0", dmem_req); else passes++;
    checks++; if (wb_valid !== 1'b0) $display("FAIL rst_wb_valid got=%b req=0", wb_valid); else passes++;
    checks++;
    if ({wb_data, wb_rd, wb_reg_write, wb_cflag, wb_zflag} !== 22'd0)
      $display("FAIL rst_wb_fields got=%h/%h/%b%b%b req=0", wb_data, wb_rd, wb_reg_write, wb_cflag, wb_zflag);
    else passes++;
    checks++; if (mem_fwd_valid !== 1'b0) $display("FAIL rst_fwd_valid got=%b req=0", mem_fwd_valid); else passes++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_passthrough();
    int acc;
    bit stalled;
    obs_q.delete(); exp_q.delete(); gnt_lat = 0; rv_lat = 1;
    issue(6'b000000, 16'h1234, 16'($urandom), 1'b1, 3'd3, 1'($urandom), 1'($urandom), acc);
    checks++;
    if (mem_fwd_valid !== 1'b1 || Data_from_mem !== 16'h1234)
      $display("FAIL pt_forward got=%b/%h req=1/1234", mem_fwd_valid, Data_from_mem);
    else passes++;
    stalled = !ex_ready;
    repeat (3) begin tick(); if (!ex_ready) stalled = 1'b1; end
    checks++; if (stalled) $display("FAIL pt_ex_ready got=0 req=1"); else passes++;
    checks++;
    if (obs_q.size() != 1) $display("FAIL pt_wb_count got=%0d req=1", obs_q.size());
    else passes++;
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0].cyc != acc + 1) $display("FAIL pt_wb_cycle got=%0d req=%0d", obs_q[0].cyc, acc + 1);
      else passes++;
      checks++;
      if (obs_q[0].data !== 16'h1234 || obs_q[0].rd !== 3'd3 || obs_q[0].rw !== 1'b1 ||
          obs_q[0].c !== exp_q[0].c || obs_q[0].z !== exp_q[0].z)
        $display("FAIL pt_wb_fields got=%h/%0d/%b%b%b req=1234/3/1%b%b", obs_q[0].data, obs_q[0].rd,
                 obs_q[0].rw, obs_q[0].c, obs_q[0].z, exp_q[0].c, exp_q[0].z);
      else passes++;
    end
  endtask

  task automatic test_store();
    int acc;
    int reqc;
    int ready_cyc;
    bit stable;
    obs_q.delete(); exp_q.delete(); gnt_lat = 2; rv_lat = 1;
    issue(6'b010100, 16'h0040, 16'hBEEF, 1'b1, 3'd2, 1'($urandom), 1'($urandom), acc);
    reqc = 0; ready_cyc = -1; stable = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (dmem_req) begin
        reqc++;
        if (dmem_we !== 1'b1 || dmem_addr !== 16'h0040 || dmem_wdata !== 16'hBEEF) stable = 1'b0;
      end
      if (ex_ready && ready_cyc < 0) ready_cyc = cyc;
      tick();
    end
    checks++; if (reqc != 3) $display("FAIL st_req_cycles got=%0d req=3", reqc); else passes++;
    checks++; if (!stable) $display("FAIL st_req_stable got=unstable req=stable"); else passes++;
    checks++; if (ready_cyc != acc + 2) $display("FAIL st_ready_cycle got=%0d req=%0d", ready_cyc, acc + 2); else passes++;
    checks++;
    if (obs_q.size() != 1) $display("FAIL st_wb_count got=%0d req=1", obs_q.size());
    else passes++;
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0].cyc != acc + 3 || obs_q[0].rw !== 1'b0 || obs_q[0].data !== 16'h0040)
        $display("FAIL st_wb got=cyc%0d/rw%b/%h req=cyc%0d/rw0/0040", obs_q[0].cyc, obs_q[0].rw,
                 obs_q[0].data, acc + 3);
      else passes++;
    end
  endtask

  task automatic test_load();
    int acc;
    int stall_n;
    logic exp_z;
    obs_q.delete(); exp_q.delete(); gnt_lat = 0; rv_lat = 3;
    set_mem(8'h10, 16'h0000);
    issue(6'b010010, 16'h0010, 16'($urandom), 1'b1, 3'd5, 1'b1, 1'b0, acc);
    checks++; if (mem_fwd_valid !== 1'b0) $display("FAIL ld_fwd_valid got=%b req=0", mem_fwd_valid); else passes++;
    stall_n = 0;
    while (mem_stall && stall_n < 20) begin stall_n++; tick(); end
    checks++; if (stall_n != 3) $display("FAIL ld_stall_cycles got=%0d req=3", stall_n); else passes++;
    wait_wb(1);
`ifdef MEM_LOAD_ZFLAG_EN
    exp_z = 1'b1;
`else
    exp_z = 1'b0;
`endif
    checks++;
    if (obs_q.size() != 1) $display("FAIL ld_wb_count got=%0d req=1", obs_q.size());
    else passes++;
    if (obs_q.size() >= 1) begin
      checks++;
      if (obs_q[0].cyc != acc + 4) $display("FAIL ld_wb_cycle got=%0d req=%0d", obs_q[0].cyc, acc + 4);
      else passes++;
      checks++;
      if (obs_q[0].data !== 16'h0000 || obs_q[0].rd !== 3'd5 || obs_q[0].rw !== 1'b1 ||
          obs_q[0].c !== 1'b1 || obs_q[0].z !== exp_z)
        $display("FAIL ld_wb_fields got=%h/%0d/%b%b%b req=0000/5/11%b", obs_q[0].data, obs_q[0].rd,
                 obs_q[0].rw, obs_q[0].c, obs_q[0].z, exp_z);
      else passes++;
    end
  endtask

  task automatic test_back_to_back();
    int acc1;
    int acc2;
    int g;
    int r;
    obs_q.delete(); exp_q.delete();
    g = $urandom_range(0, 2); r = $urandom_range(1, 3);
    gnt_lat = g; rv_lat = r;
    issue(6'b010001, 16'($urandom_range(0, 255)), 16'($urandom), 1'b1, 3'd1, 1'($urandom), 1'($urandom), acc1);
    issue(6'b000011, 16'($urandom), 16'($urandom), 1'b1, 3'd6, 1'($urandom), 1'($urandom), acc2);
    wait_wb(2);
    checks++;
    if (obs_q.size() != 2) $display("FAIL b2b_wb_count got=%0d req=2", obs_q.size());
    else passes++;
    if (obs_q.size() >= 2) begin
      checks++;
      if (obs_q[0].cyc != acc1 + g + r + 1) $display("FAIL b2b_load_cycle got=%0d req=%0d", obs_q[0].cyc, acc1 + g + r + 1);
      else passes++;
      checks++;
      if (acc2 != obs_q[0].cyc || obs_q[1].cyc != obs_q[0].cyc + 1)
        $display("FAIL b2b_timing got=acc%0d/wb%0d req=acc%0d/wb%0d", acc2, obs_q[1].cyc, obs_q[0].cyc, obs_q[0].cyc + 1);
      else passes++;
      for (int i = 0; i < 2; i++) begin
        checks++;
        if ({obs_q[i].data, obs_q[i].rd, obs_q[i].rw, obs_q[i].c, obs_q[i].z} !==
            {exp_q[i].data, exp_q[i].rd, exp_q[i].rw, exp_q[i].c, exp_q[i].z})
          $display("FAIL b2b_wb%0d got=%h/%0d/%b%b%b req=%h/%0d/%b%b%b", i, obs_q[i].data, obs_q[i].rd,
                   obs_q[i].rw, obs_q[i].c, obs_q[i].z, exp_q[i].data, exp_q[i].rd, exp_q[i].rw,
                   exp_q[i].c, exp_q[i].z);
        else passes++;
      end
    end
  endtask

  task automatic test_lm();
    int acc;
    logic [7:0] base;
    obs_q.delete(); exp_q.delete(); gnt_lat = 0; rv_lat = 1;
    base = 8'($urandom_range(16, 200));
    for (int i = 0; i < 4; i++) set_mem(base + 8'(i), (i == 1) ? 16'h0000 : 16'($urandom_range(1, 65535)));
    for (int i = 0; i < 4; i++)
      issue({4'b0110, 2'($urandom)}, {8'h00, base + 8'(i)}, 16'($urandom), 1'b1, 3'(i + 4),
            1'($urandom), 1'($urandom), acc);
    wait_wb(4);
    checks++;
    if (obs_q.size() != 4) $display("FAIL lm_wb_count got=%0d req=4", obs_q.size());
    else passes++;
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].rd, obs_q[i].rw, obs_q[i].c, obs_q[i].z} !==
          {exp_q[i].data, exp_q[i].rd, exp_q[i].rw, exp_q[i].c, exp_q[i].z})
        $display("FAIL lm_wb%0d got=%h/%0d/%b%b%b req=%h/%0d/%b%b%b", i, obs_q[i].data, obs_q[i].rd,
                 obs_q[i].rw, obs_q[i].c, obs_q[i].z, exp_q[i].data, exp_q[i].rd, exp_q[i].rw,
                 exp_q[i].c, exp_q[i].z);
      else passes++;
      if (i > 0) begin
        checks++;
        if (obs_q[i].cyc != obs_q[i-1].cyc + 2)
          $display("FAIL lm_spacing%0d got=%0d req=%0d", i, obs_q[i].cyc, obs_q[i-1].cyc + 2);
        else passes++;
      end
    end
  endtask

  task automatic test_reset_mid();
    int acc;
    obs_q.delete(); exp_q.delete(); gnt_lat = 0; rv_lat = 10;
    issue(6'b010000, 16'h0020, 16'($urandom), 1'b1, 3'd7, 1'b0, 1'b0, acc);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; resp_en = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 16'hFFFF;
    tick();
    checks++; if (wb_valid !== 1'b0) $display("FAIL rm_wb_valid got=%b req=0", wb_valid); else passes++;
    checks++; if (dmem_req !== 1'b0) $display("FAIL rm_dmem_req got=%b req=0", dmem_req); else passes++;
    checks++; if (ex_ready !== 1'b1) $display("FAIL rm_ex_ready got=%b req=1", ex_ready); else passes++;
    dmem_rvalid = 1'b0; resp_en = 1'b1;
    repeat (3) tick();
    checks++; if (obs_q.size() != 0) $display("FAIL rm_stray_wb got=%0d req=0", obs_q.size()); else passes++;
    exp_q.delete();
  endtask

  task automatic test_random();
    int acc;
    int n;
    int cls;
    logic [5:0] op;
    logic [15:0] a;
    n = 60;
    obs_q.delete(); exp_q.delete(); stray_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      cls = $urandom_range(0, 2);
      op = 6'($urandom);
      if (cls == 0) begin
        while (op[5:2] >= 4'd4 && op[5:2] <= 4'd7) op = 6'($urandom);
        a = 16'($urandom);
      end else begin
        op[5:2] = (cls == 1) ? ($urandom_range(0, 1) ? 4'b0110 : 4'b0100)
                             : ($urandom_range(0, 1) ? 4'b0111 : 4'b0101);
        a = 16'($urandom_range(0, 15));
      end
      gnt_lat = $urandom_range(0, 3); rv_lat = $urandom_range(1, 3);
      repeat ($urandom_range(0, 2)) tick();
      issue(op, a, 16'($urandom), 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), acc);
    end
    wait_wb(n);
    stray_en = 1'b0;
    checks++;
    if (obs_q.size() != n) $display("FAIL rnd_wb_count got=%0d req=%0d", obs_q.size(), n);
    else passes++;
    for (int i = 0; i < n && i < obs_q.size(); i++) begin
      checks++;
      if ({obs_q[i].data, obs_q[i].rd, obs_q[i].rw, obs_q[i].c, obs_q[i].z} !==
          {exp_q[i].data, exp_q[i].rd, exp_q[i].rw, exp_q[i].c, exp_q[i].z})
        $display("FAIL rnd_wb%0d got=%h/%0d/%b%b%b req=%h/%0d/%b%b%b", i, obs_q[i].data, obs_q[i].rd,
                 obs_q[i].rw, obs_q[i].c, obs_q[i].z, exp_q[i].data, exp_q[i].rd, exp_q[i].rw,
                 exp_q[i].c, exp_q[i].z);
      else passes++;
    end
  endtask

  initial begin
    ex_valid = 1'b0; opcode_ex = '0; alu_out = '0; Data_2_ex_updated = '0;
    reg_write_ex_updated = 1'b0; rd_ex = '0; cout_n = 1'b0; zout_n = 1'b0;
    for (int i = 0; i < 256; i++) set_mem(8'(i), 16'($urandom));
    test_reset();
    test_passthrough();
    test_store();
    test_load();
    test_back_to_back();
    test_lm();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog cycles=%0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
